mult_datapath: RTL
==================

# mult_datapath

Register and arithmetic datapath for the 8-bit signed add-shift multiplier. It holds the sign-extension bit X, the accumulator A and the multiplier/product register B. It executes the single-cycle strobes issued by the sequencing FSM (setA, loadA, subtract, shift) and a user load strobe, and flags completion after the eighth shift. It sits directly downstream of the multiplier control FSM, and its outputs drive the LEDs and hex displays.

## Interface
- WIDTH, 8, operand width; A, B and S are WIDTH bits; the adder is WIDTH+1 bits.
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high.
- S  in  WIDTH  multiplicand (switches); also the source for loading B.
- ClearA_LoadB  in  1  user strobe: clear X and A, load B from S.
- setA  in  1  controller strobe: clear X and A at the start of a multiply.
- loadA  in  1  controller strobe: conditional add (or subtract) of S into A.
- subtract  in  1  qualifies loadA; selects A − S instead of A + S.
- shift  in  1  controller strobe: arithmetic right shift of {X, A, B}.
- Aval  out  WIDTH  current A (product high byte).
- Bval  out  WIDTH  current B (product low byte).
- Xval  out  1  sign-extension bit.
- Done  out  1  high once eight shifts have completed since the last clear.

## Operation
- Reset: X=0, A=0, B=0, shift count=0, Done=0. Every output is registered, so all outputs read 0 the cycle after Reset.
- Priority when strobes coincide: Reset > setA > loadA > shift > ClearA_LoadB. Only the highest-priority strobe acts.
- setA: X←0, A←0, count←0, Done←0. B is held.
- loadA, B[0]=1:
  - sum9 = {A[7],A} + ({S[7],S} XOR {9{subtract}}) + subtract, computed 9-bit two's complement.
  - {X,A} ← sum9.
- loadA, B[0]=0: X, A and B are held.
- subtract without loadA: no effect.
- shift: X held; A ← {X, A[7:1]}; B ← {A[0], B[7:1]}; count ← min(count+1, 8).
- Done ← 1 on the edge on which count reaches 8. It stays high until the next setA, ClearA_LoadB or Reset.
- ClearA_LoadB: X←0, A←0, B←S, count←0, Done←0. It is ignored in any cycle where setA, loadA or shift is high.
- Final product is the signed 16-bit value {A,B}. X equals A[7] after every completed multiply.
- Re-running without ClearA_LoadB multiplies S by the low byte left in B from the previous run (consecutive-multiply behaviour).

## Timing
- Every strobe is single-cycle. The result is visible on Aval/Bval/Xval in the cycle after the strobe edge.
- Expected controller sequence: setA, then eight pairs of loadA followed by shift. The eighth loadA carries subtract=1.
- From the setA edge to Done=1 is 17 edges.
- The adder is purely combinational from the current A, S and subtract. There is no pipelining.
- S must be stable during any loadA cycle. Changing S mid-multiply affects only the loadA cycles that follow.
- Reset asserted mid-multiply aborts the operation: all state returns to reset values on that edge. Strobes in the same cycle are ignored.
- A shift received when count=8 is still performed; count saturates and Done stays 1.

## Structure
- Shared package mult_pkg:
  - WIDTH default constant.
  - Typedef for the 9-bit extended word.
  - Constant for the shift count (8).
- Sub-module add_sub9: combinational 9-bit adder/subtractor.
  - Inputs: a[8:0], b[8:0], sub.
  - Output: s[8:0].
  - Built as a ripple of full adders.
- The top level holds:
  - the X/A/B registers and the 4-bit shift counter;
  - the Done flag;
  - the priority-encoded next-state logic.

## Test plan
- Reset, then ClearA_LoadB with S=0x03 → A=0x00, B=0x03, X=0, Done=0 the next cycle.
- B=0x03, setA, then 8×(loadA, shift) with S=0x07 and subtract on the last loadA → A=0x00, B=0x15, X=0, Done=1 after 17 edges.
- B=0x03, S=0xF9 (−7), same sequence → A=0xFF, B=0xEB, X=1 (−21).
- B=0x80, S=0x80 → A=0x40, B=0x00, X=0 (+16384). This checks that the 9-bit final subtract does not overflow.
- Repeat the multiply without ClearA_LoadB: S=0x02 with B left at 0x15 → A=0x00, B=0x2A.
- Reset asserted during the fourth shift → all outputs 0 next cycle. loadA asserted together with ClearA_LoadB → only the add takes effect and B is unchanged.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and types for the 8-bit signed add-shift multiplier datapath.
package mult_pkg;

  localparam int WIDTH = 8;

  // Operand plus one sign-extension bit, the width of the adder.
  typedef logic [WIDTH:0] ext_word_t;

  localparam logic [3:0] SHIFT_COUNT = 4'd8;

endpackage

// File: rtl/add_sub9.sv
// Combinational 9-bit ripple adder/subtractor: s = a + (b ^ {9{sub}}) + sub.
module add_sub9
  import mult_pkg::*;
(
  input  ext_word_t a,
  input  ext_word_t b,
  input  logic      sub,
  output ext_word_t s
);

  ext_word_t b_x;
  ext_word_t carry;

  assign b_x      = b ^ {(WIDTH + 1){sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign s[i] = a[i] ^ b_x[i] ^ carry[i];
    if (i < WIDTH) begin : g_carry
      assign carry[i+1] = (a[i] & b_x[i]) | (a[i] & carry[i]) | (b_x[i] & carry[i]);
    end
  end

endmodule

// File: rtl/mult_datapath.sv
// X/A/B register datapath for the signed add-shift multiplier, driven by
// single-cycle strobes from the sequencing FSM and a user load strobe.
module mult_datapath
  import mult_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] S,
  input  logic             ClearA_LoadB,
  input  logic             setA,
  input  logic             loadA,
  input  logic             subtract,
  input  logic             shift,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Done
);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  ext_word_t        sum9;

  add_sub9 u_add_sub9 (
    .a   ({a_q[WIDTH-1], a_q}),
    .b   ({S[WIDTH-1], S}),
    .sub (subtract),
    .s   (sum9)
  );

  // Strobe priority: setA > loadA > shift > ClearA_LoadB; Reset is applied in the register.
  always_comb begin
    x_d    = x_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (setA) begin
      x_d    = 1'b0;
      a_d    = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (loadA) begin
      if (b_q[0]) begin
        {x_d, a_d} = sum9;
      end
    end else if (shift) begin
      a_d = {x_q, a_q[WIDTH-1:1]};
      b_d = {a_q[0], b_q[WIDTH-1:1]};
      if (cnt_q < SHIFT_COUNT) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (cnt_q >= SHIFT_COUNT - 4'd1) begin
        done_d = 1'b1;
      end
    end else if (ClearA_LoadB) begin
      x_d    = 1'b0;
      a_d    = '0;
      b_d    = S;
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign Done = done_q;

endmodule
